sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised successor of the team's 16x8 synchronous FIFO. It adds configurable width and depth, a fill-level count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also offers a selectable read mode: registered (standard) or first-word-fall-through (FWFT). It is a single-clock buffer used between producer and consumer stages inside one clock domain of the synchroniser datapath.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
AF_THRESH, 2**ADDR_W-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a valid word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_W+1  current number of stored words
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=0, async) sets: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit. count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- empty: pointers are equal. full: MSBs differ and low bits are equal.
- All status flags are combinational from the registered pointers, so they reflect an accepted operation on the cycle after its clock edge.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO is accepted when a read is accepted in the same cycle; count is unchanged.
- When both are accepted while empty is impossible (rd_acc=0 when empty): the write is accepted, the read is rejected, and underflow is set.
- Pointers increment by 1 on acceptance and wrap naturally at 2**(ADDR_W+1).
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] at the clock edge; rd_valid=1 for that one following cycle, otherwise 0.
  - Read latency is 1 cycle.
  - rd_data holds its last value when no read occurs.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr[ADDR_W-1:0]] combinationally; rd_valid = !empty.
  - rd_acc pops the head word; the next word appears the following cycle.
  - A word written into an empty FIFO is visible on rd_data one cycle after the write edge.
- Errors:
  - overflow is set on wr_en & !wr_acc.
  - underflow is set on rd_en & empty.
  - Both flags hold until clr_err=1.
  - If clr_err and a new error occur in the same cycle, set wins.
  - Rejected operations never move pointers or modify memory.
- Asynchronous reset mid-operation aborts everything immediately. Data present before reset is lost: empty=1 after reset, and no stale rd_valid.
- AF_THRESH and AE_THRESH must lie in 1..DEPTH; out-of-range values are a parameter error flagged by an elaboration-time check.

Decomposition:
- Shared header/package sync_fifo_defs holds the default widths and the threshold-check macro/function.
- One sub-module, fifo_ram: a DEPTH x DATA_W dual-port RAM with one synchronous write port and one asynchronous read port.
- Pointer, flag, error and read-mode logic live in the top module.

Test Plan:
1. DATA_W=8, ADDR_W=4, FWFT=0; reset; write 0x00..0x0F -> full=1, count=16, almost_full from count=14; read 16 times -> data returned in order 0x00..0x0F, each with rd_valid one cycle after rd_en; empty=1 at end.
2. Full FIFO; wr_en=1 with rd_en=0 -> overflow=1, count stays 16, mem[0] still 0x00. Then pulse clr_err -> overflow=0.
3. Full FIFO; wr_en=1 and rd_en=1 together with wr_data=0xA5 -> read returns 0x00, write accepted, count stays 16, no overflow; 0xA5 read out last.
4. Empty FIFO; rd_en=1 -> underflow=1, rd_valid=0. Same-cycle wr_en (0x3C) -> count=1, 0x3C readable next.
5. FWFT=1; write 0x11 into empty FIFO -> rd_data=0x11, rd_valid=1 on the next cycle without rd_en; write 0x22 then rd_en=1 -> rd_data=0x22 the following cycle.
6. Pointer wrap: 40 interleaved writes and reads, keeping count between 3 and 5 -> data order preserved across wrap and almost_empty toggles at count<=2. Assert rst=0 mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_defs.sv
// Shared defaults and parameter sanity helpers for the parametrised sync FIFO.
package sync_fifo_defs;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Thresholds are compared against the fill level, so only 1..depth is meaningful.
  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram
  import sync_fifo_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost thresholds, sticky error flags and
// selectable registered or first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_defs::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = 2**ADDR_W - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

  if (!thresh_ok(AF_THRESH, DEPTH)) begin : g_af_bad
    $error("sync_fifo_param: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (!thresh_ok(AE_THRESH, DEPTH)) begin : g_ae_bad
    $error("sync_fifo_param: AE_THRESH=%0d outside 1..%0d", AE_THRESH, DEPTH);
  end

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // A full FIFO still takes a write when the head is popped in the same cycle;
  // the async read port returns the old word before the write lands.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = (overflow_q & ~clr_err) | (wr_en & ~wr_acc);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // FWFT exposes the head word directly; standard mode uses the registered copy.
  assign rd_data   = FWFT ? ram_rdata : rd_data_q;
  assign rd_valid  = FWFT ? ~empty : rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param in standard and FWFT modes.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic       s_wr_en = 0, s_rd_en = 0, s_clr = 0;
  logic [7:0] s_wr_data = 0, s_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] s_count;

  logic       f_wr_en = 0, f_rd_en = 0, f_clr = 0;
  logic [7:0] f_wr_data = 0, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic       m_ovf = 0, m_udf = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int n, input logic [4:0] cnt,
                            input logic fl, input logic em, input logic af, input logic ae);
    chk({tag, "_count"}, 32'(cnt), 32'(n));
    chk({tag, "_full"}, 32'(fl), 32'(n == 16));
    chk({tag, "_empty"}, 32'(em), 32'(n == 0));
    chk({tag, "_af"}, 32'(af), 32'(n >= 14));
    chk({tag, "_ae"}, 32'(ae), 32'(n <= 2));
  endtask

  // One standard-mode cycle: the model decides acceptance, clock, then compare.
  task automatic op_s(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic       racc, wacc;
    logic [7:0] exp_d;
    racc  = rd && (sq.size() > 0);
    wacc  = wr && ((sq.size() < 16) || racc);
    exp_d = 8'h00;
    m_ovf = (m_ovf & ~clr) | (wr & ~wacc);
    m_udf = (m_udf & ~clr) | (rd & (sq.size() == 0));
    if (racc) exp_d = sq.pop_front();
    if (wacc) sq.push_back(d);
    s_wr_en = wr; s_wr_data = d; s_rd_en = rd; s_clr = clr;
    @(posedge clk); #1;
    s_wr_en = 0; s_rd_en = 0; s_clr = 0;
    chk("s_rd_valid", 32'(s_rd_valid), 32'(racc));
    if (racc) chk("s_rd_data", 32'(s_rd_data), 32'(exp_d));
    chk_status("s", sq.size(), s_count, s_full, s_empty, s_af, s_ae);
    chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
    chk("s_underflow", 32'(s_udf), 32'(m_udf));
  endtask

  task automatic op_f(input logic wr, input logic [7:0] d, input logic rd);
    logic racc, wacc;
    racc = rd && (fq.size() > 0);
    wacc = wr && ((fq.size() < 16) || racc);
    if (racc) void'(fq.pop_front());
    if (wacc) fq.push_back(d);
    f_wr_en = wr; f_wr_data = d; f_rd_en = rd;
    @(posedge clk); #1;
    f_wr_en = 0; f_rd_en = 0;
    chk("f_rd_valid", 32'(f_rd_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) chk("f_rd_data", 32'(f_rd_data), 32'(fq[0]));
    chk_status("f", fq.size(), f_count, f_full, f_empty, f_af, f_ae);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_rd_valid"}, 32'(s_rd_valid), 0);
    chk({tag, "_s_rd_data"}, 32'(s_rd_data), 0);
    chk({tag, "_s_ovf"}, 32'(s_ovf), 0);
    chk({tag, "_s_udf"}, 32'(s_udf), 0);
    chk_status({tag, "_s"}, 0, s_count, s_full, s_empty, s_af, s_ae);
    chk({tag, "_f_rd_valid"}, 32'(f_rd_valid), 0);
    chk_status({tag, "_f"}, 0, f_count, f_full, f_empty, f_af, f_ae);
  endtask

  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Fill the standard FIFO; almost_full rises at 14, full at 16.
    for (int i = 0; i < 16; i++) op_s(1, 8'(i), 0, 0);

    // Overflow while full, then clear it.
    op_s(1, 8'hEE, 0, 0);
    op_s(0, 8'h00, 0, 1);

    // Simultaneous read/write when full: 0x00 out, 0xA5 in, count holds.
    op_s(1, 8'hA5, 1, 0);
    for (int i = 0; i < 16; i++) op_s(0, 8'h00, 1, 0);

    // Underflow on empty; same-cycle write is still taken.
    op_s(0, 8'h00, 1, 0);
    op_s(1, 8'h3C, 1, 0);
    op_s(0, 8'h00, 1, 1);

    // FWFT head visibility and pop.
    op_f(1, 8'h11, 0);
    op_f(1, 8'h22, 0);
    op_f(0, 8'h00, 1);
    op_f(0, 8'h00, 1);

    // Interleaved traffic long enough to wrap both pointers.
    for (int i = 0; i < 4; i++) begin
      op_s(1, 8'($urandom), 0, 0);
      op_f(1, 8'($urandom), 0);
    end
    for (int i = 0; i < 40; i++) begin
      op_s(1, 8'($urandom), 0, 0);
      op_s(0, 8'h00, 1, 0);
      op_f(1, 8'($urandom), 0);
      op_f(0, 8'h00, 1);
    end
    for (int i = 0; i < 3; i++) begin
      op_s(0, 8'h00, 1, 0);
      op_f(0, 8'h00, 1);
    end

    // Asynchronous reset in the middle of a cycle with data buffered.
    s_wr_en = 1; s_wr_data = 8'h77; f_wr_en = 1; f_wr_data = 8'h77;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    s_wr_en = 0; f_wr_en = 0;
    sq.delete(); fq.delete();
    chk_reset("async_rst");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    op_s(1, 8'h5A, 0, 0);
    op_s(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
